// File: rtl/lbm_pkg.sv
// Shared types and constants for the LBM lattice renderer.
// Direction order matches the lattice word layout in the BRAM.
package lbm_pkg;

    localparam logic [1:0] LBM_SETUP     = 2'd0;
    localparam logic [1:0] LBM_COLLISION = 2'd1;
    localparam logic [1:0] LBM_STREAMING = 2'd2;
    localparam logic [1:0] LBM_WAITING   = 2'd3;

    localparam int DIR_C  = 0;
    localparam int DIR_N  = 1;
    localparam int DIR_NE = 2;
    localparam int DIR_E  = 3;
    localparam int DIR_SE = 4;
    localparam int DIR_S  = 5;
    localparam int DIR_SW = 6;
    localparam int DIR_W  = 7;
    localparam int DIR_NW = 8;

    typedef logic [8:0][7:0] lattice_word_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    function automatic logic [3:0] sat15(input logic [7:0] v);
        return (v > 8'd15) ? 4'hF : v[3:0];
    endfunction

endpackage

// File: rtl/lbm_moments.sv
// Registered moment stage: density and, with LBM_RENDER_SPEED_EN,
// the signed x/y momentum of one lattice cell.
module lbm_moments
    import lbm_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  lattice_word_t       data,
    output logic [11:0]         density
`ifdef LBM_RENDER_SPEED_EN
    ,
    output logic signed [10:0]  ux,
    output logic signed [10:0]  uy
`endif
);

    logic [11:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < 9; i++) begin
            sum = sum + 12'(data[i]);
        end
    end

`ifdef LBM_RENDER_SPEED_EN
    logic [10:0] east, west, north, south;

    // 11-bit wrap gives the right two's complement: |diff| <= 765
    assign east  = 11'(data[DIR_NE]) + 11'(data[DIR_E])
                 + 11'(data[DIR_SE]);
    assign west  = 11'(data[DIR_NW]) + 11'(data[DIR_W])
                 + 11'(data[DIR_SW]);
    assign north = 11'(data[DIR_N]) + 11'(data[DIR_NE])
                 + 11'(data[DIR_NW]);
    assign south = 11'(data[DIR_S]) + 11'(data[DIR_SE])
                 + 11'(data[DIR_SW]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            density <= '0;
`ifdef LBM_RENDER_SPEED_EN
            ux      <= '0;
            uy      <= '0;
`endif
        end else begin
            density <= sum;
`ifdef LBM_RENDER_SPEED_EN
            ux      <= signed'(east - west);
            uy      <= signed'(north - south);
`endif
        end
    end

endmodule

// File: rtl/lbm_render.sv
// Lattice-to-frame-buffer renderer; scans the LBM BRAM while the engine waits.
// Optional speed view is built when LBM_RENDER_SPEED_EN is defined.
module lbm_render
    import lbm_pkg::*;
#(
    parameter int HPIXELS   = 320,
    parameter int VPIXELS   = 180,
    parameter int BRAM_SIZE = $clog2(HPIXELS * VPIXELS)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 frame_req_in,
    input  logic [1:0]           lbm_state_in,
    input  logic                 mode_in,
    input  lattice_word_t        bram_data_in,
    output logic                 rd_own_out,
    output logic [BRAM_SIZE-1:0] addr_out,
    output logic [BRAM_SIZE-1:0] pixel_addr_out,
    output logic [11:0]          pixel_data_out,
    output logic                 pixel_valid_out,
    output logic                 done_out,
    output logic                 abort_out
);

    localparam logic [BRAM_SIZE-1:0] LAST_ADDR =
        BRAM_SIZE'(HPIXELS * VPIXELS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]           state;
    logic                 req;
    logic                 v1, v2, v3;
    logic [BRAM_SIZE-1:0] a1, a2, a3;
    logic [11:0]          density;
    logic                 waiting;
    logic                 pending;
    logic [3:0]           grey;
    rgb444_t              colour;

    assign waiting = (lbm_state_in == LBM_WAITING);
    assign pending = req | frame_req_in;

`ifdef LBM_RENDER_SPEED_EN
    logic signed [10:0] ux, uy;
    logic [10:0]        ax, ay, speed;
    logic [3:0]         red;
    logic               mode;

    lbm_moments u_moments (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .data    (bram_data_in),
        .density (density),
        .ux      (ux),
        .uy      (uy)
    );

    always_comb begin
        ax    = ux[10] ? 11'(-ux) : 11'(ux);
        ay    = uy[10] ? 11'(-uy) : 11'(uy);
        speed = ax + ay;
        red   = sat15(speed[10:3]);
    end
`else
    logic unused_mode;

    assign unused_mode = mode_in;

    lbm_moments u_moments (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .data    (bram_data_in),
        .density (density)
    );
`endif

    always_comb begin
        grey   = sat15({1'b0, density[11:5]});
        colour = '{r: grey, g: grey, b: grey};
`ifdef LBM_RENDER_SPEED_EN
        if (mode) colour = '{r: red, g: 4'h0, b: 4'hF - red};
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= S_IDLE;
            req             <= 1'b0;
            rd_own_out      <= 1'b0;
            addr_out        <= '0;
            v1              <= 1'b0;
            v2              <= 1'b0;
            v3              <= 1'b0;
            a1              <= '0;
            a2              <= '0;
            a3              <= '0;
            pixel_addr_out  <= '0;
            pixel_data_out  <= '0;
            pixel_valid_out <= 1'b0;
            done_out        <= 1'b0;
            abort_out       <= 1'b0;
`ifdef LBM_RENDER_SPEED_EN
            mode            <= 1'b0;
`endif
        end else begin
            done_out        <= 1'b0;
            abort_out       <= 1'b0;
            if (frame_req_in) req <= 1'b1;
            // address and valid ride alongside the BRAM/moment latency
            v1              <= (state == S_SCAN) && waiting;
            a1              <= addr_out;
            v2              <= v1;
            a2              <= a1;
            v3              <= v2;
            a3              <= a2;
            pixel_valid_out <= v3;
            pixel_addr_out  <= a3;
            pixel_data_out  <= colour;
            unique case (state)
                S_IDLE: begin
                    if (pending) state <= S_ARM;
                end
                S_ARM: begin
                    if (waiting) begin
                        state      <= S_SCAN;
                        addr_out   <= '0;
                        rd_own_out <= 1'b1;
                        req        <= frame_req_in;
`ifdef LBM_RENDER_SPEED_EN
                        mode       <= mode_in;
`endif
                    end
                end
                S_SCAN: begin
                    if (!waiting) begin
                        state           <= S_ARM;
                        rd_own_out      <= 1'b0;
                        abort_out       <= 1'b1;
                        req             <= 1'b1;
                        v2              <= 1'b0;
                        v3              <= 1'b0;
                        pixel_valid_out <= 1'b0;
                    end else if (addr_out == LAST_ADDR) begin
                        state      <= S_DRAIN;
                        rd_own_out <= 1'b0;
                    end else begin
                        addr_out <= addr_out + BRAM_SIZE'(1);
                    end
                end
                S_DRAIN: begin
                    if (!(v1 | v2 | v3)) begin
                        done_out <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbm_render.sv
// Self-checking bench for lbm_render on a 4x2 lattice with a 2-cycle BRAM.
// Expected pixels come from a plain-integer reference of the colour rules.
module tb_lbm_render;
    import lbm_pkg::*;

    localparam int N  = 8;
    localparam int AW = 3;
`ifdef LBM_RENDER_SPEED_EN
    localparam bit SPEED = 1'b1;
`else
    localparam bit SPEED = 1'b0;
`endif

    typedef logic [11:0] pix_arr_t [N];
    typedef struct {
        string         name;
        lattice_word_t w;
        bit            m;
        logic [11:0]   exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_req = 1'b0;
    logic [1:0]    lbm_state = 2'd3;
    logic          mode = 1'b0;
    lattice_word_t bram_data = '0;
    lattice_word_t rd1 = '0;
    logic          rd_own;
    logic [AW-1:0] addr;
    logic [AW-1:0] paddr;
    logic [11:0]   pdata;
    logic          pvalid;
    logic          done;
    logic          abort;

    lattice_word_t mem [N];
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;

    logic [AW-1:0] wq_addr[$];
    logic [11:0]   wq_data[$];
    int            wq_cyc[$];
    logic [AW-1:0] iq_addr[$];
    int            iq_cyc[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            abort_cnt = 0;
    int            own_cnt = 0;

    lbm_render #(.HPIXELS(4), .VPIXELS(2)) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .frame_req_in    (frame_req),
        .lbm_state_in    (lbm_state),
        .mode_in         (mode),
        .bram_data_in    (bram_data),
        .rd_own_out      (rd_own),
        .addr_out        (addr),
        .pixel_addr_out  (paddr),
        .pixel_data_out  (pdata),
        .pixel_valid_out (pvalid),
        .done_out        (done),
        .abort_out       (abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rd1       <= mem[addr];
        bram_data <= rd1;
    end

    always @(negedge clk) begin
        if (pvalid) begin
            wq_addr.push_back(paddr);
            wq_data.push_back(pdata);
            wq_cyc.push_back(cyc);
        end
        if (rd_own) begin
            iq_addr.push_back(addr);
            iq_cyc.push_back(cyc);
            own_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (abort) abort_cnt++;
    end

    function automatic lattice_word_t mk(int c, int n, int ne, int e,
                                         int se, int s, int sw, int w,
                                         int nw);
        lattice_word_t x;
        x[DIR_C]  = 8'(c);
        x[DIR_N]  = 8'(n);
        x[DIR_NE] = 8'(ne);
        x[DIR_E]  = 8'(e);
        x[DIR_SE] = 8'(se);
        x[DIR_S]  = 8'(s);
        x[DIR_SW] = 8'(sw);
        x[DIR_W]  = 8'(w);
        x[DIR_NW] = 8'(nw);
        return x;
    endfunction

    function automatic logic [11:0] ref_pix(lattice_word_t w, bit m);
        int b[9];
        int d, ux, uy, s, r, g;
        d = 0;
        for (int i = 0; i < 9; i++) begin
            b[i] = int'(w[i]);
            d += b[i];
        end
        ux = b[DIR_NE] + b[DIR_E] + b[DIR_SE]
           - b[DIR_NW] - b[DIR_W] - b[DIR_SW];
        uy = b[DIR_N] + b[DIR_NE] + b[DIR_NW]
           - b[DIR_S] - b[DIR_SE] - b[DIR_SW];
        if (SPEED && m) begin
            s = (ux < 0 ? -ux : ux) + (uy < 0 ? -uy : uy);
            r = s / 8;
            if (r > 15) r = 15;
            return {4'(r), 4'h0, 4'(15 - r)};
        end
        g = d / 32;
        if (g > 15) g = 15;
        return {4'(g), 4'(g), 4'(g)};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_req();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
    endtask

    task automatic wait_done(int target);
        int k = 0;
        while (done_cnt < target && k < 400) begin
            tick();
            k++;
        end
        check("done_seen", 32'(done_cnt >= target), 1);
    endtask

    task automatic wait_addr(int a);
        int k = 0;
        while (!(rd_own && addr == AW'(a)) && k < 100) begin
            tick();
            k++;
        end
        check("reach_addr", 32'(rd_own && addr == AW'(a)), 1);
    endtask

    task automatic check_frame(int ws, int is, pix_arr_t exp);
        int n, wc, lat;
        n = wq_addr.size() - ws;
        check("frame_writes", n, N);
        for (int k = 0; k < N; k++) begin
            if (ws + k < wq_addr.size()) begin
                wc = wq_cyc[ws + k];
                check("pixel_addr", 32'(wq_addr[ws + k]), k);
                check("pixel_data", 32'(wq_data[ws + k]), 32'(exp[k]));
                lat = -1;
                for (int j = iq_addr.size() - 1; j >= is; j--) begin
                    if (lat < 0 && iq_addr[j] == AW'(k) && iq_cyc[j] < wc)
                        lat = wc - iq_cyc[j];
                end
                check("latency", lat, 4);
            end
        end
        if (n >= N) check("done_timing", done_cyc, wq_cyc[ws + N - 1] + 1);
    endtask

    task automatic run_frame(bit m, bit flip, pix_arr_t exp);
        int ws, is, d0, k;
        ws = wq_addr.size();
        is = iq_addr.size();
        d0 = done_cnt;
        mode = m;
        pulse_req();
        if (flip) begin
            k = 0;
            while (!rd_own && k < 50) begin
                tick();
                k++;
            end
            mode = ~m;
        end
        wait_done(d0 + 1);
        check_frame(ws, is, exp);
    endtask

    task automatic fill_all(lattice_word_t w);
        for (int k = 0; k < N; k++) mem[k] = w;
    endtask

    function automatic pix_arr_t ref_frame(bit m);
        pix_arr_t e;
        for (int k = 0; k < N; k++) e[k] = ref_pix(mem[k], m);
        return e;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t     vecs[9];
        pix_arr_t e;
        int       ws, is, d0, a0, o0, dc;

        vecs[0] = '{"all28", mk(28,28,28,28,28,28,28,28,28), 0, 12'h777};
        vecs[1] = '{"east80", mk(0,0,80,80,80,0,0,0,0), 1,
                    SPEED ? 12'hF00 : 12'h777};
        vecs[2] = '{"west80", mk(0,0,0,0,0,0,80,80,80), 1,
                    SPEED ? 12'hF00 : 12'h777};
        vecs[3] = '{"zero", mk(0,0,0,0,0,0,0,0,0), 1,
                    SPEED ? 12'h00F : 12'h000};
        vecs[4] = '{"all255", mk(255,255,255,255,255,255,255,255,255),
                    0, 12'hFFF};
        vecs[5] = '{"c31", mk(31,0,0,0,0,0,0,0,0), 0, 12'h000};
        vecs[6] = '{"c32", mk(32,0,0,0,0,0,0,0,0), 0, 12'h111};
        vecs[7] = '{"e8", mk(0,0,0,8,0,0,0,0,0), 1,
                    SPEED ? 12'h10E : 12'h000};
        vecs[8] = '{"n119", mk(0,119,0,0,0,0,0,0,0), 1,
                    SPEED ? 12'hE01 : 12'h333};

        fill_all('0);
        tick();
        tick();
        check("reset_outputs",
              32'({rd_own, addr, paddr, pdata, pvalid, done, abort}), 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_outputs",
              32'({rd_own, addr, paddr, pdata, pvalid, done, abort}), 0);

        foreach (vecs[v]) begin
            fill_all(vecs[v].w);
            for (int k = 0; k < N; k++) e[k] = vecs[v].exp;
            run_frame(vecs[v].m, 1'b0, e);
        end

        // abort at address 3, then full rescan
        for (int k = 0; k < N; k++) mem[k] = mk(k*20, 1, 2, 3, 4, 5, 6, 7, k);
        ws = wq_addr.size();
        a0 = abort_cnt;
        pulse_req();
        wait_addr(3);
        lbm_state = 2'd2;
        tick();
        check("abort_own_drop", 32'(rd_own), 0);
        check("abort_pulse", 32'(abort), 1);
        repeat (6) tick();
        check("abort_once", abort_cnt - a0, 1);
        check("abort_no_writes", wq_addr.size() - ws, 0);
        check("abort_own_low", 32'(rd_own), 0);
        ws = wq_addr.size();
        is = iq_addr.size();
        d0 = done_cnt;
        lbm_state = 2'd3;
        wait_done(d0 + 1);
        check_frame(ws, is, ref_frame(0));
        check("abort_total", abort_cnt - a0, 1);

        // request while engine busy: wait in ARM
        lbm_state = 2'd1;
        ws = wq_addr.size();
        is = iq_addr.size();
        o0 = own_cnt;
        d0 = done_cnt;
        pulse_req();
        repeat (10) tick();
        check("arm_no_own", own_cnt - o0, 0);
        check("arm_no_writes", wq_addr.size() - ws, 0);
        lbm_state = 2'd3;
        wait_done(d0 + 1);
        check_frame(ws, is, ref_frame(0));

        // second request during scan gives exactly one more frame
        ws = wq_addr.size();
        is = iq_addr.size();
        d0 = done_cnt;
        pulse_req();
        tick();
        tick();
        pulse_req();
        wait_done(d0 + 1);
        check_frame(ws, is, ref_frame(0));
        ws = wq_addr.size();
        is = iq_addr.size();
        wait_done(d0 + 2);
        check_frame(ws, is, ref_frame(0));
        o0 = own_cnt;
        repeat (30) tick();
        check("no_third_frame", done_cnt - d0, 2);
        check("no_third_own", own_cnt - o0, 0);

        // request coincident with done
        d0 = done_cnt;
        pulse_req();
        wait_done(d0 + 1);
        dc = done_cyc;
        ws = wq_addr.size();
        is = iq_addr.size();
        pulse_req();
        wait_done(d0 + 2);
        check_frame(ws, is, ref_frame(0));
        if (iq_cyc.size() > is) check("req_at_done", iq_cyc[is] - dc, 2);
        else check("req_at_done", 0, 2);

        // randomized frames, mode changed mid-scan must not matter
        for (int r = 0; r < 6; r++) begin
            bit m;
            for (int k = 0; k < N; k++)
                for (int b = 0; b < 9; b++)
                    mem[k][b] = 8'($urandom_range(0, (r % 2) ? 255 : 60));
            m = 1'($urandom_range(0, 1));
            run_frame(m, 1'b1, ref_frame(m));
        end
        mode = 1'b0;

        // asynchronous reset mid-scan
        pulse_req();
        wait_addr(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset",
              32'({rd_own, addr, paddr, pdata, pvalid, done, abort}), 0);
        tick();
        tick();
        rst_n = 1'b1;
        d0 = done_cnt;
        a0 = abort_cnt;
        o0 = own_cnt;
        repeat (20) tick();
        check("post_reset_done", done_cnt - d0, 0);
        check("post_reset_abort", abort_cnt - a0, 0);
        check("post_reset_own", own_cnt - o0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
